// File: rtl/adc_idelay_pkg.sv
// adc_idelay_pkg: shared types and defaults for the IDELAYE2 tap controller.
// Holds the FSM state encoding and lane/tap width defaults.
package adc_idelay_pkg;

  localparam int LANES_DEF = 28;
  localparam int TAP_W_DEF = 5;
  localparam int LANE_W    = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    STEP,
    SETTLE,
    LOAD,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/adc_idelay_tap_ctrl_if.sv
// adc_idelay_tap_ctrl_if: command handshake bundle for the tap controller.
// The master issues lane/tap moves or a global reload; the slave accepts.
interface adc_idelay_tap_ctrl_if
  import adc_idelay_pkg::*;
#(
  parameter int TAP_W = TAP_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_load;
  logic [LANE_W-1:0] cmd_lane;
  logic [TAP_W-1:0]  cmd_tap;

  modport master (
    output cmd_valid,
    output cmd_load,
    output cmd_lane,
    output cmd_tap,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_load,
    input  cmd_lane,
    input  cmd_tap,
    output cmd_ready
  );

endinterface

// File: rtl/adc_idelay_tap_bank.sv
// adc_idelay_tap_bank: per-lane tracked tap registers.
// Decodes a single step request into one-hot CE/INC for the selected lane.
module adc_idelay_tap_bank
  import adc_idelay_pkg::*;
#(
  parameter int LANES    = LANES_DEF,
  parameter int TAP_W    = TAP_W_DEF,
  parameter int INIT_TAP = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step,
  input  logic                   up,
  input  logic                   load,
  input  logic [LANE_W-1:0]      lane,
  output logic [LANES-1:0]       ce,
  output logic [LANES-1:0]       inc,
  output logic [LANES*TAP_W-1:0] tap_flat,
  output logic [TAP_W-1:0]       sel_tap
);

  logic [TAP_W-1:0] tap [LANES];

  always_comb begin
    ce      = '0;
    inc     = '0;
    sel_tap = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane == LANE_W'(i)) begin
        ce[i]   = step;
        inc[i]  = step & up;
        sel_tap = tap[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || load) begin
      for (int i = 0; i < LANES; i++)
        tap[i] <= TAP_W'(INIT_TAP);
    end else begin
      for (int i = 0; i < LANES; i++)
        if (ce[i])
          tap[i] <= inc[i] ? tap[i] + 1'b1
                           : tap[i] - 1'b1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_flat
    assign tap_flat[g*TAP_W +: TAP_W] = tap[g];
  end

endmodule

// File: rtl/adc_idelay_tap_ctrl.sv
// adc_idelay_tap_ctrl: walks one IDELAYE2 lane to a target tap, one CE per
// settle window. Define ADC_IDLY_READBACK_EN to verify CNTVALUEOUT in CHECK.
module adc_idelay_tap_ctrl
  import adc_idelay_pkg::*;
#(
  parameter int LANES      = LANES_DEF,
  parameter int TAP_W      = TAP_W_DEF,
  parameter int INIT_TAP   = 4,
  parameter int SETTLE_CYC = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   idly_rdy,
  adc_idelay_tap_ctrl_if.slave   cmd,
  input  logic                   err_clr,
  output logic [LANES-1:0]       idly_ce,
  output logic [LANES-1:0]       idly_inc,
  output logic [LANES-1:0]       idly_rst,
  output logic [LANES*TAP_W-1:0] tap_cur,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic [LANES*TAP_W-1:0] idly_cnt
);

  localparam int SC_W =
    (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  state_t            state, nxt;
  logic [LANE_W-1:0] lane_q;
  logic [TAP_W-1:0]  tgt_q;
  logic [TAP_W-1:0]  sel_tap;
  logic [SC_W-1:0]   cnt;
  logic              accept;
  logic              last;
  logic              step;
  logic              up;
  logic              load;
  logic              set_err;
  logic              cnt_bad;
  logic              ready;

  assign cmd.cmd_ready = ready;
  assign accept = cmd.cmd_valid & ready;
  assign last   = cnt == SC_W'(SETTLE_CYC - 1);

`ifdef ADC_IDLY_READBACK_EN
  logic [TAP_W-1:0] cnt_sel;

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < LANES; i++)
      if (lane_q == LANE_W'(i))
        cnt_sel = idly_cnt[i*TAP_W +: TAP_W];
  end

  assign cnt_bad = cnt_sel != sel_tap;
`else
  logic cnt_unused;
  assign cnt_unused = ^idly_cnt;
  assign cnt_bad    = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= IDLE;
      lane_q <= '0;
      tgt_q  <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        lane_q <= cmd.cmd_lane;
        tgt_q  <= cmd.cmd_tap;
      end
      cnt <= (state == SETTLE) ? cnt + 1'b1 : '0;
      if (set_err)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

  always_comb begin
    nxt     = state;
    ready   = 1'b0;
    step    = 1'b0;
    up      = 1'b0;
    load    = 1'b0;
    set_err = 1'b0;
    done    = 1'b0;
    busy    = state != IDLE;
    unique case (state)
      IDLE: begin
        ready = idly_rdy;
        if (accept) begin
          if (cmd.cmd_load) begin
            nxt = LOAD;
          end else if (int'(cmd.cmd_lane) >= LANES) begin
            set_err = 1'b1;
            nxt     = DONE;
          end else begin
            nxt = STEP;
          end
        end
      end
      WAIT_RDY: begin
        if (idly_rdy)
          nxt = STEP;
      end
      STEP: begin
        if (!idly_rdy) begin
          nxt = WAIT_RDY;
        end else if (tgt_q != sel_tap) begin
          step = 1'b1;
          up   = tgt_q > sel_tap;
          nxt  = SETTLE;
        end else begin
          nxt = CHECK;
        end
      end
      SETTLE: begin
        if (!idly_rdy)
          nxt = WAIT_RDY;
        else if (last)
          nxt = STEP;
      end
      LOAD: begin
        load = 1'b1;
        nxt  = DONE;
      end
      CHECK: begin
        set_err = cnt_bad;
        nxt     = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign idly_rst = {LANES{load}};

  adc_idelay_tap_bank #(
    .LANES    (LANES),
    .TAP_W    (TAP_W),
    .INIT_TAP (INIT_TAP)
  ) u_bank (
    .clk      (aclk),
    .rst      (areset),
    .step     (step),
    .up       (up),
    .load     (load),
    .lane     (lane_q),
    .ce       (idly_ce),
    .inc      (idly_inc),
    .tap_flat (tap_cur),
    .sel_tap  (sel_tap)
  );

endmodule

// File: tb/tb_adc_idelay_tap_ctrl.sv
// tb_adc_idelay_tap_ctrl: scoreboard bench for the IDELAY tap controller.
// Driver queues expected results per command; a monitor checks them at done.
module tb_adc_idelay_tap_ctrl;

  localparam int LANES = 28;
  localparam int TAP_W = 5;
  localparam logic [LANES*TAP_W-1:0] ALL4 = {LANES{5'd4}};

  logic                   aclk = 1'b0;
  logic                   areset;
  logic                   idly_rdy;
  logic                   err_clr;
  logic [LANES-1:0]       idly_ce;
  logic [LANES-1:0]       idly_inc;
  logic [LANES-1:0]       idly_rst;
  logic [LANES*TAP_W-1:0] tap_cur;
  logic [LANES*TAP_W-1:0] idly_cnt;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic                   force3;

  adc_idelay_tap_ctrl_if #(.TAP_W(TAP_W)) cmd_if ();

  adc_idelay_tap_ctrl #(
    .LANES      (LANES),
    .TAP_W      (TAP_W),
    .INIT_TAP   (4),
    .SETTLE_CYC (4)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .idly_rdy (idly_rdy),
    .cmd      (cmd_if),
    .err_clr  (err_clr),
    .idly_ce  (idly_ce),
    .idly_inc (idly_inc),
    .idly_rst (idly_rst),
    .tap_cur  (tap_cur),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .idly_cnt (idly_cnt)
  );

  always #5 aclk = ~aclk;

  // IDELAY model: CNTVALUEOUT follows the taps unless lane 3 is stuck at 7
  always_comb begin
    idly_cnt = tap_cur;
    if (force3)
      idly_cnt[15 +: 5] = 5'd7;
  end

  typedef struct {
    int lane;
    int tap;
    int err;
    int incs;
    int decs;
    int rsts;
    int all4;
    int lat;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(int lane, int tap, int e, int incs,
                              int decs, int rsts, int all4, int lat);
    exp_t x;
    x.lane = lane; x.tap = tap; x.err = e;
    x.incs = incs; x.decs = decs; x.rsts = rsts;
    x.all4 = all4; x.lat = lat;
    return x;
  endfunction

  always @(posedge aclk) cyc++;

  // monitor
  int incs, decs, rsts, bad, ce_low, gap_bad, last_p, acc_cyc;
  bit dropped;

  always @(negedge aclk) begin
    if (areset) begin
      incs = 0; decs = 0; rsts = 0; bad = 0;
      ce_low = 0; gap_bad = 0; last_p = -1; dropped = 0;
    end else begin
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) acc_cyc = cyc + 1;
      if (!idly_rdy) dropped = 1;
      if (idly_ce != '0) begin
        if (!$onehot(idly_ce)) bad++;
        if (!idly_rdy) ce_low++;
        if (last_p >= 0 && !dropped && cyc - last_p != 5) gap_bad++;
        last_p = cyc;
        dropped = 0;
        if ((idly_inc & idly_ce) != '0) incs++;
        else decs++;
      end
      if ((idly_inc & ~idly_ce) != '0) bad++;
      if (idly_rst == '1) rsts++;
      else if (idly_rst != '0) bad++;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t  e;
          string n;
          e = q.pop_front();
          n = nq.pop_front();
          if (e.lane >= 0)
            chk({n, "_tap"}, int'(tap_cur[e.lane*5 +: 5]), e.tap);
          if (e.all4 != 0)
            chk({n, "_all4"}, int'(tap_cur == ALL4), 1);
          chk({n, "_err"}, int'(err), e.err);
          chk({n, "_incs"}, incs, e.incs);
          chk({n, "_decs"}, decs, e.decs);
          chk({n, "_rsts"}, rsts, e.rsts);
          chk({n, "_ce_bad"}, bad, 0);
          chk({n, "_ce_rdylow"}, ce_low, 0);
          chk({n, "_gap"}, gap_bad, 0);
          if (e.lat > 0)
            chk({n, "_lat"}, cyc - acc_cyc + 1, e.lat);
        end
        incs = 0; decs = 0; rsts = 0; bad = 0;
        ce_low = 0; gap_bad = 0; last_p = -1; dropped = 0;
      end
    end
  end

  task automatic issue(input string n, input exp_t e,
                       input logic ld, input int lane, input int tap);
    int k = 0;
    while (!cmd_if.cmd_ready && k < 500) begin
      @(posedge aclk); #1; k++;
    end
    if (!cmd_if.cmd_ready) chk({n, "_ready_timeout"}, 0, 1);
    q.push_back(e);
    nq.push_back(n);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_load  = ld;
    cmd_if.cmd_lane  = 5'(lane);
    cmd_if.cmd_tap   = 5'(tap);
    @(posedge aclk); #1;
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string n);
    int k = 0;
    while (busy && k < 3000) begin
      @(posedge aclk); #1; k++;
    end
    if (busy) chk({n, "_busy_timeout"}, 1, 0);
  endtask

  task automatic run(input string n, input exp_t e,
                     input logic ld, input int lane, input int tap);
    issue(n, e, ld, lane, tap);
    wait_idle(n);
    @(posedge aclk); #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge aclk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    int quiet;
    areset = 1'b1;
    idly_rdy = 1'b1;
    err_clr = 1'b0;
    force3 = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_load  = 1'b0;
    cmd_if.cmd_lane  = '0;
    cmd_if.cmd_tap   = '0;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(posedge aclk); #1;

    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ce", int'(idly_ce != '0), 0);
    chk("rst_ld", int'(idly_rst != '0), 0);
    chk("rst_taps", int'(tap_cur == ALL4), 1);
    chk("rst_ready", int'(cmd_if.cmd_ready), 1);

    // lane 3: 4 -> 9, five increments
    run("l3_up", mk(3, 9, 0, 5, 0, 0, 0, 28), 1'b0, 3, 9);
    // lane 27: 4 -> 0, four decrements
    run("l27_dn", mk(27, 0, 0, 0, 4, 0, 0, 23), 1'b0, 27, 0);
    // out-of-range lane
    run("l30_err", mk(-1, 0, 1, 0, 0, 0, 0, 1), 1'b0, 30, 5);
    pulse_clr();
    chk("err_clr", int'(err), 0);

    // lane 0: 4 -> 20 with idly_rdy low for 10 cycles
    issue("l0_drop", mk(0, 20, 0, 16, 0, 0, 0, -1), 1'b0, 0, 20);
    repeat (12) @(posedge aclk);
    #1 idly_rdy = 1'b0;
    repeat (10) @(posedge aclk);
    #1 idly_rdy = 1'b1;
    wait_idle("l0_drop");
    @(posedge aclk); #1;

    // target equals current: no pulses
    run("l5_eq", mk(5, 4, 0, 0, 0, 0, 0, 3), 1'b0, 5, 4);
    // walk to top and bottom boundaries
    run("l1_top", mk(1, 31, 0, 27, 0, 0, 0, 138), 1'b0, 1, 31);
    run("l1_bot", mk(1, 0, 0, 0, 31, 0, 0, 158), 1'b0, 1, 0);
    // global reload
    run("load", mk(-1, 4, 0, 0, 0, 1, 1, 2), 1'b1, 0, 0);

`ifdef ADC_IDLY_READBACK_EN
    force3 = 1'b1;
    run("rdbk", mk(3, 9, 1, 5, 0, 0, 0, 28), 1'b0, 3, 9);
    force3 = 1'b0;
    pulse_clr();
    chk("rdbk_clr", int'(err), 0);
`endif

    // reset in the middle of a move aborts it
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_load  = 1'b0;
    cmd_if.cmd_lane  = 5'd2;
    cmd_if.cmd_tap   = 5'd20;
    @(posedge aclk); #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (8) @(posedge aclk);
    #1 areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    quiet = 0;
    repeat (20) begin
      if (idly_ce != '0 || done) quiet++;
      @(posedge aclk); #1;
    end
    chk("abort_quiet", quiet, 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_taps", int'(tap_cur == ALL4), 1);

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
